// File: rtl/board_ctrl.sv
// board_ctrl: 3-in-a-row game-state controller (board, turns, move accept/reject, win/draw/timeout)
module board_ctrl #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         TURN_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       winner,
    input  logic [1:0] who_win,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic       move_ack,
    output logic       move_nack,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] result
);
    typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [1:0]  cells [9];
    logic [3:0]  move_cnt;
    logic [31:0] turn_cnt;
    logic        cell_free, accept, expire, reject, finish;

    assign pos1 = cells[0];
    assign pos2 = cells[1];
    assign pos3 = cells[2];
    assign pos4 = cells[3];
    assign pos5 = cells[4];
    assign pos6 = cells[5];
    assign pos7 = cells[6];
    assign pos8 = cells[7];
    assign pos9 = cells[8];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PLAY;
        else        state <= state_next;
    end

    // Next state: a written move is always followed by one CHECK cycle; DONE only leaves via new_game
    always_comb begin
        state_next = state;
        if (new_game)                      state_next = PLAY;
        else if (state == PLAY && accept)  state_next = CHECK;
        else if (state == CHECK)           state_next = finish ? DONE : PLAY;
    end

    // Move/timeout decode; an accepted move beats expiry, and expiry swallows a nack so pulses never overlap
    always_comb begin
        cell_free = 1'b0;
        for (int i = 0; i < 9; i++)
            if (move_pos == 4'(i + 1)) cell_free = (cells[i] == 2'b00);
        accept = (state == PLAY) && move_valid && cell_free;
        expire = (TURN_TIMEOUT != 0) && (state == PLAY) && !accept &&
                 (turn_cnt == 32'(TURN_TIMEOUT - 1));
        reject = move_valid && !accept && !expire;
        finish = (state == CHECK) && (winner || move_cnt == 4'd9);
    end

    // Board, turn, counters, pulses and result; new_game acts as a synchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            turn      <= FIRST_PLAYER;
            move_cnt  <= 4'd0;
            turn_cnt  <= 32'd0;
            move_ack  <= 1'b0;
            move_nack <= 1'b0;
            timeout   <= 1'b0;
            game_over <= 1'b0;
            result    <= 2'b00;
        end else if (new_game) begin
            for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
            turn      <= FIRST_PLAYER;
            move_cnt  <= 4'd0;
            turn_cnt  <= 32'd0;
            move_ack  <= 1'b0;
            move_nack <= 1'b0;
            timeout   <= 1'b0;
            game_over <= 1'b0;
            result    <= 2'b00;
        end else begin
            move_ack  <= accept;
            move_nack <= reject;
            timeout   <= expire;
            for (int i = 0; i < 9; i++)
                if (accept && move_pos == 4'(i + 1)) cells[i] <= turn;
            if (accept && move_cnt != 4'd9) move_cnt <= move_cnt + 4'd1;
            turn_cnt <= (TURN_TIMEOUT != 0 && state == PLAY && !accept && !expire) ?
                        turn_cnt + 32'd1 : 32'd0;
            if (expire || (state == CHECK && !finish)) turn <= ~turn;
            if (state == CHECK && winner) begin
                result    <= who_win;
                game_over <= 1'b1;
            end else if (finish) begin
                result    <= 2'b11;
                game_over <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed test of board_ctrl (timeout off and TURN_TIMEOUT=4) against a behavioural game model
module tb_board_ctrl;
    localparam int TO1 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;

    logic [1:0] p0 [9];
    logic [1:0] p1 [9];
    logic [1:0] turn0, turn1, res0, res1, who0, who1;
    logic       ack0, ack1, nack0, nack1, to0, to1, go0, go1, win0, win1;
    logic [8:0][1:0] board0, board1;

    int n_cmp = 0;
    int n_err = 0;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    board_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid), .move_pos(move_pos),
        .winner(win0), .who_win(who0),
        .pos1(p0[0]), .pos2(p0[1]), .pos3(p0[2]), .pos4(p0[3]), .pos5(p0[4]),
        .pos6(p0[5]), .pos7(p0[6]), .pos8(p0[7]), .pos9(p0[8]),
        .turn(turn0), .move_ack(ack0), .move_nack(nack0), .timeout(to0),
        .game_over(go0), .result(res0)
    );

    board_ctrl #(.FIRST_PLAYER(2'b01), .TURN_TIMEOUT(TO1)) u1 (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid), .move_pos(move_pos),
        .winner(win1), .who_win(who1),
        .pos1(p1[0]), .pos2(p1[1]), .pos3(p1[2]), .pos4(p1[3]), .pos5(p1[4]),
        .pos6(p1[5]), .pos7(p1[6]), .pos8(p1[7]), .pos9(p1[8]),
        .turn(turn1), .move_ack(ack1), .move_nack(nack1), .timeout(to1),
        .game_over(go1), .result(res1)
    );

    function automatic logic [1:0] win_of(input logic [8:0][1:0] b);
        win_of = 2'b00;
        for (int l = 0; l < 8; l++)
            if (b[lines[l][0]] != 2'b00 && b[lines[l][0]] == b[lines[l][1]] &&
                b[lines[l][0]] == b[lines[l][2]])
                win_of = b[lines[l][0]];
    endfunction

    // detect_win stand-in: combinational on each DUT's board
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            board0[i] = p0[i];
            board1[i] = p1[i];
        end
        who0 = win_of(board0);
        who1 = win_of(board1);
        win0 = (who0 != 2'b00);
        win1 = (who1 != 2'b00);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural game model: board, whose turn, result, pending-check flag, idle cycles this turn
    logic [8:0][1:0] mb [2];
    logic [1:0] mt [2], mr [2];
    logic       ma [2], mn [2], mo [2], mc [2];
    int         mtc [2];

    task automatic model_step(input int m, input int tmo);
        int p, filled;
        logic [1:0] w;
        ma[m] = 1'b0; mn[m] = 1'b0; mo[m] = 1'b0;
        p = int'(move_pos);
        if (mc[m]) begin
            mc[m] = 1'b0;
            w = win_of(mb[m]);
            filled = 0;
            for (int i = 0; i < 9; i++) if (mb[m][i] != 2'b00) filled++;
            if (w != 2'b00)      mr[m] = w;
            else if (filled == 9) mr[m] = 2'b11;
            else                  mt[m] = (mt[m] == 2'b01) ? 2'b10 : 2'b01;
            mn[m] = move_valid;
        end else if (mr[m] != 2'b00) begin
            mn[m] = move_valid;
        end else if (move_valid && p >= 1 && p <= 9 && mb[m][p-1] == 2'b00) begin
            mb[m][p-1] = mt[m];
            ma[m] = 1'b1;
            mc[m] = 1'b1;
            mtc[m] = 0;
        end else if (tmo > 0 && mtc[m] + 1 == tmo) begin
            mt[m] = (mt[m] == 2'b01) ? 2'b10 : 2'b01;
            mo[m] = 1'b1;
            mtc[m] = 0;
        end else begin
            mn[m] = move_valid;
            if (tmo > 0) mtc[m]++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n || new_game) begin
                    mb[m] = '0; mt[m] = 2'b01; mr[m] = 2'b00;
                    ma[m] = 1'b0; mn[m] = 1'b0; mo[m] = 1'b0; mc[m] = 1'b0; mtc[m] = 0;
                end else begin
                    model_step(m, m == 0 ? 0 : TO1);
                end
            end
        end
    end

    // Every-cycle comparison of all outputs of both instances against the model
    initial begin
        #1;
        forever begin
            @(negedge clk);
            check("u0 outputs", {6'd0, board0, turn0, ack0, nack0, to0, go0, res0},
                  {6'd0, mb[0], mt[0], ma[0], mn[0], mo[0], mr[0] != 2'b00, mr[0]});
            check("u1 outputs", {6'd0, board1, turn1, ack1, nack1, to1, go1, res1},
                  {6'd0, mb[1], mt[1], ma[1], mn[1], mo[1], mr[1] != 2'b00, mr[1]});
        end
    end

    // Move request for one cycle, check u0 ack/nack, then one idle cycle
    task automatic mv(input int p, input logic exp_ack, input string name);
        @(negedge clk);
        move_valid = 1'b1;
        move_pos = 4'(p);
        @(negedge clk);
        move_valid = 1'b0;
        check(name, {30'd0, ack0, nack0}, exp_ack ? 32'd2 : 32'd1);
        @(negedge clk);
    endtask

    task automatic ng();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset board", 32'(board0), 32'd0);
        check("reset turn", 32'(turn0), 32'd1);
        check("reset flags", {27'd0, ack0, nack0, to0, go0, res0}, 32'd0);

        // P1 wins on the top row
        mv(1, 1'b1, "t1 P1@1");
        mv(4, 1'b1, "t1 P2@4");
        mv(2, 1'b1, "t1 P1@2");
        mv(5, 1'b1, "t1 P2@5");
        mv(3, 1'b1, "t1 P1@3");
        check("t1 pos1", 32'(p0[0]), 32'd1);
        check("t1 pos2", 32'(p0[1]), 32'd1);
        check("t1 pos3", 32'(p0[2]), 32'd1);
        check("t1 result", 32'(res0), 32'd1);
        check("t1 game_over", 32'(go0), 32'd1);

        // Occupied cell
        ng();
        mv(5, 1'b1, "t2 P1@5");
        mv(5, 1'b0, "t2 P2@5 occupied");
        check("t2 pos5", 32'(p0[4]), 32'd1);
        check("t2 turn", 32'(turn0), 32'd2);

        // Out-of-range cells, then a move during CHECK
        mv(0, 1'b0, "t3 pos0");
        mv(10, 1'b0, "t3 pos10");
        mv(15, 1'b0, "t3 pos15");
        check("t3 board", 32'(board0), 32'h100);
        check("t3 turn", 32'(turn0), 32'd2);
        @(negedge clk);
        move_valid = 1'b1;
        move_pos = 4'd1;
        @(negedge clk);
        check("t3 P2@1 ack", 32'(ack0), 32'd1);
        move_pos = 4'd2;
        @(negedge clk);
        move_valid = 1'b0;
        check("t3 check-cycle nack", 32'(nack0), 32'd1);
        check("t3 pos2 empty", 32'(p0[1]), 32'd0);
        check("t3 pos1", 32'(p0[0]), 32'd2);
        check("t3 turn back", 32'(turn0), 32'd1);

        // Full-board draw, move in DONE, then new_game
        ng();
        for (int i = 0; i < 9; i++) mv(seq[i], 1'b1, "t4 draw move");
        check("t4 result", 32'(res0), 32'd3);
        check("t4 game_over", 32'(go0), 32'd1);
        mv(1, 1'b0, "t4 done nack");
        check("t4 result frozen", 32'(res0), 32'd3);
        ng();
        check("t4 board clear", 32'(board0), 32'd0);
        check("t4 turn", 32'(turn0), 32'd1);
        check("t4 result clear", {30'd0, res0}, 32'd0);

        // Turn timeout on the TURN_TIMEOUT=4 instance
        ng();
        repeat (3) @(negedge clk);
        check("t5 no timeout yet", 32'(to1), 32'd0);
        check("t5 turn before", 32'(turn1), 32'd1);
        @(negedge clk);
        check("t5 timeout pulse", 32'(to1), 32'd1);
        check("t5 turn after", 32'(turn1), 32'd2);
        check("t5 no timeout u0", {30'd0, to0, turn0 == 2'b01}, 32'd1);
        repeat (3) @(negedge clk);
        move_valid = 1'b1;
        move_pos = 4'd1;
        @(negedge clk);
        move_valid = 1'b0;
        check("t5 expiry ack", {30'd0, ack1, to1}, 32'd2);
        check("t5 expiry pos1", 32'(p1[0]), 32'd2);
        @(negedge clk);

        // new_game beats a simultaneous move; async reset during CHECK
        @(negedge clk);
        new_game = 1'b1;
        move_valid = 1'b1;
        move_pos = 4'd2;
        @(negedge clk);
        new_game = 1'b0;
        move_valid = 1'b0;
        check("t6 no ack", {30'd0, ack0, ack1}, 32'd0);
        check("t6 board0 clear", 32'(board0), 32'd0);
        check("t6 board1 clear", 32'(board1), 32'd0);
        @(negedge clk);
        move_valid = 1'b1;
        move_pos = 4'd3;
        @(negedge clk);
        move_valid = 1'b0;
        check("t6 ack before reset", 32'(ack0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async board", 32'(board0), 32'd0);
        check("t6 async turn", 32'(turn0), 32'd1);
        check("t6 async flags", {22'd0, ack0, nack0, to0, go0, res0, ack1, nack1, to1, go1, res1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mv(7, 1'b1, "t6 post-reset move");
        check("t6 pos7", 32'(p0[6]), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
